// File: rtl/ft2_bus_arbiter.sv
// FT2232H synchronous-FIFO bus arbiter: sequences RD#/WR# strobes, owns the tri-state enable and
// alternates RX/TX with bounded bursts. Define FT2_ARB_STATS_EN to add saturating byte counters.
module ft2_bus_arbiter #(
  parameter int BURST_MAX   = 64,
  parameter int RD_CYCLES   = 3,
  parameter int WR_CYCLES   = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxf_n,
  input  logic       txe_n,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [1:0] grant
`ifdef FT2_ARB_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] rx_bytes,
  output logic [15:0] tx_bytes
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RX = 2'b01, S_TX = 2'b10, S_TURN = 2'b11} state_t;

  localparam logic [8:0] BURST_LIM = 9'(BURST_MAX);
  localparam logic [7:0] RD_LAST   = 8'(RD_CYCLES);
  localparam logic [7:0] RD_CAP    = 8'(RD_CYCLES - 1);
  localparam logic [7:0] WR_END    = 8'(WR_CYCLES);
  localparam logic [7:0] WR_LAST   = 8'(WR_CYCLES + 1);
  localparam logic [7:0] TURN_LAST = 8'(TURN_CYCLES - 1);

  state_t     state, state_nx, target, target_nx;
  logic [7:0] phase, phase_nx, count, count_nx;
  logic       last_tx, last_tx_nx;
  logic       rx_el, tx_el;
  logic [8:0] count_inc;

  assign rx_el     = !rxf_n && rx_ready;
  assign tx_el     = !txe_n && tx_valid;
  assign count_inc = {1'b0, count} + 9'd1;

  // Phase counts cycles within a byte; the final (recovery) phase is the only decision point.
  always_comb begin
    state_nx   = state;
    target_nx  = target;
    phase_nx   = phase + 8'd1;
    count_nx   = count;
    last_tx_nx = last_tx;
    case (state)
      S_IDLE: begin
        phase_nx = 8'd0;
        if (rx_el && (!tx_el || last_tx)) begin
          state_nx   = S_RX;
          last_tx_nx = 1'b0;
        end else if (tx_el) begin
          state_nx   = S_TX;
          last_tx_nx = 1'b1;
        end
      end
      S_RX: begin
        if (phase == RD_LAST) begin
          phase_nx = 8'd0;
          if (rx_el && (count_inc < BURST_LIM || !tx_el)) begin
            count_nx = (count_inc >= BURST_LIM) ? 8'd0 : count_inc[7:0];
          end else if (tx_el) begin
            state_nx  = S_TURN;
            target_nx = S_TX;
            count_nx  = 8'd0;
          end else begin
            state_nx = S_IDLE;
            count_nx = 8'd0;
          end
        end
      end
      S_TX: begin
        if (phase == WR_LAST) begin
          phase_nx = 8'd0;
          if (tx_el && (count_inc < BURST_LIM || !rx_el)) begin
            count_nx = (count_inc >= BURST_LIM) ? 8'd0 : count_inc[7:0];
          end else begin
            // Leaving TX always releases the bus through TURN before anyone else drives it.
            state_nx  = S_TURN;
            target_nx = rx_el ? S_RX : S_IDLE;
            count_nx  = 8'd0;
          end
        end
      end
      default: begin
        if (phase == TURN_LAST) begin
          phase_nx = 8'd0;
          state_nx = target;
          if (target == S_RX) last_tx_nx = 1'b0;
          if (target == S_TX) last_tx_nx = 1'b1;
        end
      end
    endcase
  end

  // Pin-facing outputs are registered from the next state so the FTDI sees glitch-free strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      target   <= S_IDLE;
      phase    <= 8'd0;
      count    <= 8'd0;
      last_tx  <= 1'b1;
      grant    <= 2'b00;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      d_oe     <= 1'b0;
      d_out    <= 8'd0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      state    <= state_nx;
      target   <= target_nx;
      phase    <= phase_nx;
      count    <= count_nx;
      last_tx  <= last_tx_nx;
      grant    <= state_nx;
      rd_n     <= !(state_nx == S_RX && phase_nx < RD_LAST);
      wr_n     <= !(state_nx == S_TX && phase_nx >= 8'd1 && phase_nx <= WR_END);
      d_oe     <= (state_nx == S_TX);
      rx_valid <= (state_nx == S_RX && phase_nx == RD_LAST);
      tx_ready <= (state_nx == S_TX && phase_nx == 8'd0);
      if (state_nx == S_TX && phase_nx == 8'd0) d_out <= tx_data;
      if (state == S_RX && phase == RD_CAP) rx_data <= d_in;
    end
  end

`ifdef FT2_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_bytes <= 16'd0;
      tx_bytes <= 16'd0;
    end else if (stats_clr) begin
      rx_bytes <= 16'd0;
      tx_bytes <= 16'd0;
    end else begin
      if (rx_valid && rx_bytes != 16'hFFFF) rx_bytes <= rx_bytes + 16'd1;
      if (tx_ready && tx_bytes != 16'hFFFF) tx_bytes <= tx_bytes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ft2_bus_arbiter.sv
// Directed bench for ft2_bus_arbiter (BURST_MAX=4, other parameters at their defaults).
module tb_ft2_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxf_n, txe_n, rx_ready, tx_valid;
  logic [7:0] d_in, tx_data;
  logic [7:0] d_out, rx_data;
  logic       d_oe, rd_n, wr_n, rx_valid, tx_ready;
  logic [1:0] grant;
`ifdef FT2_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] rx_bytes, tx_bytes;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ft2_bus_arbiter #(.BURST_MAX(4), .RD_CYCLES(3), .WR_CYCLES(2), .TURN_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .rxf_n(rxf_n), .txe_n(txe_n), .d_in(d_in), .d_out(d_out),
    .d_oe(d_oe), .rd_n(rd_n), .wr_n(wr_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant)
`ifdef FT2_ARB_STATS_EN
    , .stats_clr(stats_clr), .rx_bytes(rx_bytes), .tx_bytes(tx_bytes)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat [0:3];
    int         kp, rxc, txc;
    logic [1:0] eg;

    rst_n = 1'b0; rxf_n = 1'b1; txe_n = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0;
    d_in = 8'h00; tx_data = 8'h00;
`ifdef FT2_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    tick(); tick();
    check("rst_rd_n", 16'(rd_n), 16'h1);
    check("rst_wr_n", 16'(wr_n), 16'h1);
    check("rst_d_oe", 16'(d_oe), 16'h0);
    check("rst_grant", 16'(grant), 16'h0);
    check("rst_rx_valid", 16'(rx_valid), 16'h0);
    check("rst_tx_ready", 16'(tx_ready), 16'h0);
    check("rst_d_out", 16'(d_out), 16'h0);
    check("rst_rx_data", 16'(rx_data), 16'h0);
    rst_n = 1'b1;
    tick();
    check("idle_grant", 16'(grant), 16'h0);

    // RX stream: rd_n low 3 cycles, rx_valid with recovery, period 4.
    pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'hFF; pat[3] = 8'h00;
    rxf_n = 1'b0; rx_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      d_in = pat[b];
      for (int ph = 0; ph < 4; ph++) begin
        tick();
        check("rx_rd_n", 16'(rd_n), (ph < 3) ? 16'h0 : 16'h1);
        check("rx_valid", 16'(rx_valid), (ph == 3) ? 16'h1 : 16'h0);
        check("rx_grant", 16'(grant), 16'h1);
        check("rx_wr_n", 16'(wr_n), 16'h1);
        check("rx_d_oe", 16'(d_oe), 16'h0);
        if (ph == 3) check("rx_data", 16'(rx_data), 16'(pat[b]));
        if (ph == 3 && b == 2) rxf_n = 1'b1;
      end
    end
    tick();
    check("rx_end_grant", 16'(grant), 16'h0);
    check("rx_end_rd_n", 16'(rd_n), 16'h1);
    rx_ready = 1'b0;

    // TX stream: setup cycle with d_oe and tx_ready, wr_n low 2 cycles, recovery, period 4.
    pat[0] = 8'h3C; pat[1] = 8'hC3; pat[2] = 8'h81; pat[3] = 8'h00;
    tx_data = pat[0]; tx_valid = 1'b1; txe_n = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int ph = 0; ph < 4; ph++) begin
        tick();
        check("tx_wr_n", 16'(wr_n), (ph == 1 || ph == 2) ? 16'h0 : 16'h1);
        check("tx_ready", 16'(tx_ready), (ph == 0) ? 16'h1 : 16'h0);
        check("tx_d_oe", 16'(d_oe), 16'h1);
        check("tx_d_out", 16'(d_out), 16'(pat[b]));
        check("tx_grant", 16'(grant), 16'h2);
        check("tx_rd_n", 16'(rd_n), 16'h1);
        if (ph == 0) begin
          tx_data = pat[b+1];
          if (b == 2) tx_valid = 1'b0;
        end
      end
    end
    tick();
    check("tx_turn_grant", 16'(grant), 16'h3);
    check("tx_turn_d_oe", 16'(d_oe), 16'h0);
    check("tx_turn_wr_n", 16'(wr_n), 16'h1);
    tick();
    check("tx_idle_grant", 16'(grant), 16'h0);
    txe_n = 1'b1;

    // Both sides saturated: 4 RX, TURN, 4 TX, TURN, repeating; stop mid-TX with wr_n low.
    rxf_n = 1'b0; rx_ready = 1'b1; txe_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h66; d_in = 8'h99;
    rxc = 0; txc = 0;
    for (int k = 1; k <= 87; k++) begin
      tick();
      kp = (k - 1) % 34;
      eg = (kp < 16) ? 2'd1 : (kp == 16) ? 2'd3 : (kp <= 32) ? 2'd2 : 2'd3;
      check("burst_grant", 16'(grant), 16'(eg));
      check("burst_excl", 16'((!rd_n && !wr_n) || (d_oe && !rd_n)), 16'h0);
      if (rx_valid) rxc++;
      if (tx_ready) txc++;
    end
    check("burst_rx_count", 16'(rxc), 16'd12);
    check("burst_tx_count", 16'(txc), 16'd9);
    check("burst_wr_low", 16'(wr_n), 16'h0);

    // Asynchronous reset while wr_n is low.
    rst_n = 1'b0;
    #1;
    check("arst_rd_n", 16'(rd_n), 16'h1);
    check("arst_wr_n", 16'(wr_n), 16'h1);
    check("arst_d_oe", 16'(d_oe), 16'h0);
    check("arst_grant", 16'(grant), 16'h0);
    check("arst_d_out", 16'(d_out), 16'h0);
    check("arst_rx_data", 16'(rx_data), 16'h0);

    // rx_ready dropped mid-byte: byte completes, then no new strobe until rx_ready returns.
    txe_n = 1'b1; tx_valid = 1'b0; rxf_n = 1'b0; rx_ready = 1'b1; d_in = 8'h77;
    tick();
    rst_n = 1'b1;
    tick();
    check("rdrop_ph0_rd_n", 16'(rd_n), 16'h0);
    tick();
    check("rdrop_ph1_rd_n", 16'(rd_n), 16'h0);
    rx_ready = 1'b0;
    tick();
    check("rdrop_ph2_rd_n", 16'(rd_n), 16'h0);
    tick();
    check("rdrop_valid", 16'(rx_valid), 16'h1);
    check("rdrop_data", 16'(rx_data), 16'h77);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rdrop_hold_rd_n", 16'(rd_n), 16'h1);
      check("rdrop_hold_grant", 16'(grant), 16'h0);
    end
    rx_ready = 1'b1;
    tick();
    check("rdrop_resume_rd_n", 16'(rd_n), 16'h0);
    check("rdrop_resume_grant", 16'(grant), 16'h1);
    rxf_n = 1'b1;
    tick(); tick(); tick();
    check("rdrop_last_valid", 16'(rx_valid), 16'h1);
    tick();
    check("rdrop_idle_grant", 16'(grant), 16'h0);

`ifdef FT2_ARB_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("stats_clr_rx", rx_bytes, 16'h0);
    check("stats_clr_tx", tx_bytes, 16'h0);
    rxf_n = 1'b0;
    tick(); tick(); tick(); tick();
    rxf_n = 1'b1;
    tick();
    check("stats_rx_one", rx_bytes, 16'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ft2_bus_arbiter.md
# ft2_bus_arbiter

Time-shares the single 8-bit FT2232H FIFO data bus between the host-to-FPGA receive path (RXF#/RD#) and the FPGA-to-host transmit path (TXE#/WR#). Sequences every byte strobe, owns the bus tri-state enable, and alternates direction fairly with bounded bursts. Sits directly on the FTDI pins; the receive word assembler and transmit byte source connect on the fabric side.

## Interface
- BURST_MAX, 64: max bytes per grant while the other direction is waiting (1..255)
- RD_CYCLES, 3: cycles rd_n is held low per byte (≥2)
- WR_CYCLES, 2: cycles wr_n is held low per byte (≥1)
- TURN_CYCLES, 1: idle cycles (strobes high, d_oe=0) on every direction change (≥1)

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rxf_n  in  1  FTDI RX FIFO has data (active low)
- txe_n  in  1  FTDI TX FIFO has space (active low)
- d_in  in  8  bus data from FTDI
- d_out  out  8  bus data to FTDI
- d_oe  out  1  tri-state enable for d_out
- rd_n  out  1  FTDI read strobe
- wr_n  out  1  FTDI write strobe
- rx_data  out  8  received byte
- rx_valid  out  1  one-cycle strobe, rx_data valid
- rx_ready  in  1  downstream can take one more byte
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  one-cycle strobe, tx_data consumed
- grant  out  2  00 idle, 01 RX, 10 TX, 11 turnaround

## Operation
- States: IDLE, RX, TX, TURN. Reset enters IDLE.
- Eligibility, sampled only at byte start: rx_el = !rxf_n & rx_ready; tx_el = !txe_n & tx_valid.
- IDLE: both eligible → direction opposite last_served; one eligible → that one; none → stay. RX entered directly; TX entered directly (d_oe already 0, no contention).
- RX byte: rd_n low RD_CYCLES cycles; d_in registered into rx_data on last low cycle; rx_valid pulses next cycle together with rd_n high for 1 recovery cycle.
- TX byte: tx_data latched and tx_ready pulsed in setup cycle (d_oe=1, wr_n high); wr_n low WR_CYCLES cycles; 1 recovery cycle wr_n high, d_out held.
- After each byte: byte count +1. Same direction continues if still eligible and (count < BURST_MAX or other side not eligible; count resets to 0 when it would exceed). Else if other side eligible → TURN then other direction; else → IDLE (via TURN if leaving TX).
- TURN: d_oe=0, rd_n=wr_n=1 for TURN_CYCLES, then first byte of new direction; last_served updated at grant.
- Byte in progress always completes: rxf_n/txe_n deassert, tx_valid drop or rx_ready drop mid-byte ignored. Downstream must absorb one byte after dropping rx_ready.
- rd_n and wr_n never low simultaneously; d_oe never 1 while rd_n low.

## Timing
- Reset values: rd_n=1, wr_n=1, d_oe=0, d_out=0, rx_data=0, rx_valid=0, tx_ready=0, grant=00, last_served=TX, count=0. Reset mid-byte aborts asynchronously to these values.
- RX: rxf_n low in IDLE at cycle 0 → rd_n low cycles 1..RD_CYCLES, rx_valid at RD_CYCLES+1; back-to-back byte period RD_CYCLES+1.
- TX: grant at cycle 0 → setup/tx_ready cycle 1, wr_n low cycles 2..WR_CYCLES+1; period WR_CYCLES+2.
- Direction change overhead: TURN_CYCLES cycles exactly.
- grant is registered, reflects current state.

## Configuration
- FT2_ARB_STATS_EN defined: adds ports stats_clr (in 1), rx_bytes (out 16), tx_bytes (out 16); counters increment on rx_valid / tx_ready, saturate at 0xFFFF, clear synchronously on stats_clr (clear wins over increment), reset 0.
- Not defined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset mid-TX (wr_n low) → rd_n=wr_n=1, d_oe=0, grant=00 immediately, before next clk edge.
- rxf_n held low, rx_ready=1, d_in=0xA5, defaults → rd_n low 3 cycles, rx_valid every 4 cycles, rx_data=0xA5.
- tx_valid=1, txe_n=0, tx_data=0x3C → d_oe=1 with d_out=0x3C one cycle before wr_n low; wr_n low 2 cycles; tx_ready once per 4 cycles.
- Both sides continuously eligible, BURST_MAX=4 → 4 RX bytes, 1 TURN cycle, 4 TX bytes, 1 TURN cycle, repeating; first grant RX.
- rx_ready dropped during 2nd cycle of rd_n low → that byte still delivered, no further rd_n pulse until rx_ready=1.
- With FT2_ARB_STATS_EN, 70000 RX bytes → rx_bytes=0xFFFF; stats_clr pulse → 0.
